// File: rtl/pong_frame_renderer.sv
// Pong raster renderer: snapshots game state at frame start, then streams one frame of 8-bit grey pixels over valid/ready.
// Optional score bars on rows 0..3 are built when PONG_RENDER_SCORE_EN is defined.
module pong_frame_renderer #(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] ballPosition,
  input  logic [31:0] leftPaddlePosition,
  input  logic [31:0] rightPaddlePosition,
  input  logic [15:0] score,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam logic [16:0] BALL_SZ   = 17'(BALL_SIZE);
  localparam logic [16:0] PAD_W     = 17'(PADDLE_W);
  localparam logic [16:0] PAD_H     = 17'(PADDLE_H);
  localparam logic [16:0] LPAD_X    = 17'(LEFT_PADDLE_X);
  localparam logic [16:0] RPAD_X    = 17'(RIGHT_PADDLE_X);
  localparam logic [15:0] CENTRE_L  = 16'(H_RES / 2 - 1);
  localparam logic [15:0] CENTRE_R  = 16'(H_RES / 2);
  localparam logic [15:0] X_LAST    = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST    = 16'(V_RES - 1);
`ifdef PONG_RENDER_SCORE_EN
  localparam logic [16:0] BAR_MAX   = 17'(H_RES / 2 - 16);
  localparam logic [16:0] BAR_R_END = 17'(H_RES - 8);
`endif

  typedef enum logic [1:0] {IDLE, LATCH, STREAM, DONE} state_t;

  state_t      state;
  logic [15:0] ball_x, ball_y, lpad_y, rpad_y;
  logic [15:0] nx, ny;
  logic        last_pix;
  logic        load;

`ifdef PONG_RENDER_SCORE_EN
  logic [7:0]  score_l, score_r;
  logic        unused_inputs;
  assign unused_inputs = ^{leftPaddlePosition[31:16], rightPaddlePosition[31:16]};
`else
  logic        unused_inputs;
  assign unused_inputs = ^{leftPaddlePosition[31:16], rightPaddlePosition[31:16], score};
`endif

  // Bounds are widened to 17 bits so objects near 0xFFFF clip instead of wrapping onto x/y = 0.
  function automatic logic [7:0] pixel_colour(input logic [15:0] px, input logic [15:0] py);
    logic [16:0] x17, y17;
    logic        ball_hit, lpad_hit, rpad_hit, centre_hit;
`ifdef PONG_RENDER_SCORE_EN
    logic [16:0] len_l, len_r;
    logic        score_hit;
`endif
    x17 = {1'b0, px};
    y17 = {1'b0, py};
    ball_hit   = (x17 >= {1'b0, ball_x}) && (x17 < {1'b0, ball_x} + BALL_SZ) &&
                 (y17 >= {1'b0, ball_y}) && (y17 < {1'b0, ball_y} + BALL_SZ);
    lpad_hit   = (x17 >= LPAD_X) && (x17 < LPAD_X + PAD_W) &&
                 (y17 >= {1'b0, lpad_y}) && (y17 < {1'b0, lpad_y} + PAD_H);
    rpad_hit   = (x17 >= RPAD_X) && (x17 < RPAD_X + PAD_W) &&
                 (y17 >= {1'b0, rpad_y}) && (y17 < {1'b0, rpad_y} + PAD_H);
    centre_hit = ((px == CENTRE_L) || (px == CENTRE_R)) && !py[3];
    pixel_colour = 8'h00;
    if (centre_hit)           pixel_colour = 8'h40;
    if (lpad_hit || rpad_hit) pixel_colour = 8'hC0;
    if (ball_hit)             pixel_colour = 8'hFF;
`ifdef PONG_RENDER_SCORE_EN
    len_l = {7'b0, score_l, 2'b00};
    len_r = {7'b0, score_r, 2'b00};
    if (len_l > BAR_MAX) len_l = BAR_MAX;
    if (len_r > BAR_MAX) len_r = BAR_MAX;
    score_hit = (py < 16'd4) &&
                (((x17 >= 17'd8) && (x17 < 17'd8 + len_l)) ||
                 ((x17 >= BAR_R_END - len_r) && (x17 < BAR_R_END)));
    if (score_hit) pixel_colour = 8'hFF;
`endif
  endfunction

  // Output register refills when LATCH primes pixel (0,0) or a non-final beat is accepted.
  assign load = (state == LATCH) || ((state == STREAM) && pix_ready && !last_pix);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pix_valid   <= 1'b0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      pix_data    <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
      nx          <= 16'h0000;
      ny          <= 16'h0000;
      last_pix    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            ball_x  <= ballPosition[31:16];
            ball_y  <= ballPosition[15:0];
            lpad_y  <= leftPaddlePosition[15:0];
            rpad_y  <= rightPaddlePosition[15:0];
`ifdef PONG_RENDER_SCORE_EN
            score_l <= score[15:8];
            score_r <= score[7:0];
`endif
            nx      <= 16'h0000;
            ny      <= 16'h0000;
            state   <= LATCH;
          end
        end
        LATCH:   state <= STREAM;
        STREAM: begin
          if (pix_ready && last_pix) begin
            pix_valid   <= 1'b0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            last_pix    <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (load) begin
        pix_data  <= pixel_colour(nx, ny);
        pix_valid <= 1'b1;
        pix_sof   <= (nx == 16'h0000) && (ny == 16'h0000);
        pix_eol   <= (nx == X_LAST);
        last_pix  <= (nx == X_LAST) && (ny == Y_LAST);
        if (nx == X_LAST) begin
          nx <= 16'h0000;
          ny <= ny + 16'd1;
        end else begin
          nx <= nx + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Randomized bench for pong_frame_renderer on a reduced raster, checked pixel-by-pixel against a geometric model.
module tb_pong_frame_renderer;
  localparam int H   = 64;
  localparam int V   = 24;
  localparam int BS  = 8;
  localparam int PW  = 4;
  localparam int PH  = 10;
  localparam int LPX = 4;
  localparam int RPX = 56;

  logic        clk = 1'b0;
  logic        rst, enable, pix_ready;
  logic [31:0] ball_pos, lpad_pos, rpad_pos;
  logic [15:0] score;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_sof, pix_eol, frame_done;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;
  int exp_count = 0;
  int bx, by, ly, ry, sl, sr;

  pong_frame_renderer #(
    .H_RES(H), .V_RES(V), .BALL_SIZE(BS), .PADDLE_W(PW), .PADDLE_H(PH),
    .LEFT_PADDLE_X(LPX), .RIGHT_PADDLE_X(RPX)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ballPosition(ball_pos), .leftPaddlePosition(lpad_pos), .rightPaddlePosition(rpad_pos),
    .score(score), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Geometric reference: plain integer rectangles, so nothing can wrap.
  function automatic logic [7:0] ref_pix(input int x, input int y);
`ifdef PONG_RENDER_SCORE_EN
    int bar_max, ll, lr;
    bar_max = H / 2 - 16;
    ll = (4 * sl < bar_max) ? 4 * sl : bar_max;
    lr = (4 * sr < bar_max) ? 4 * sr : bar_max;
    if (y < 4 && ((x >= 8 && x < 8 + ll) || (x >= H - 8 - lr && x < H - 8))) return 8'hFF;
`endif
    if (x >= bx && x < bx + BS && y >= by && y < by + BS) return 8'hFF;
    if (x >= LPX && x < LPX + PW && y >= ly && y < ly + PH) return 8'hC0;
    if (x >= RPX && x < RPX + PW && y >= ry && y < ry + PH) return 8'hC0;
    if ((x == H / 2 - 1 || x == H / 2) && ((y / 8) % 2 == 0)) return 8'h40;
    return 8'h00;
  endfunction

  task automatic set_inputs(input int b_x, input int b_y, input int l_y, input int r_y, input logic [15:0] sc);
    ball_pos = {16'(b_x), 16'(b_y)};
    lpad_pos = {16'($urandom), 16'(l_y)};
    rpad_pos = {16'($urandom), 16'(r_y)};
    score    = sc;
    bx = b_x; by = b_y; ly = l_y; ry = r_y;
    sl = int'(sc[15:8]); sr = int'(sc[7:0]);
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge where the first pixel is visible.
  task automatic start_frame();
    enable = 1'b1;
    @(negedge clk);
    check("lat_latch_cycle", pix_valid, 1'b0);
    @(negedge clk);
    check("lat_first_valid", {pix_valid, pix_sof}, 2'b11);
  endtask

  task automatic stream_frame(input int ready_pct, input bit drop_en, input bit scramble);
    int  ex = 0;
    int  ey = 0;
    int  beats = 0;
    int  cycles = 0;
    bit  done = 1'b0;
    while (!done) begin
      if (cycles > H * V * 20 + 50) begin
        check("stream_timeout", beats, H * V);
        break;
      end
      check("pix", {frame_done, pix_valid, pix_eol, pix_sof, pix_data},
            {1'b0, 1'b1, 1'(ex == H - 1), 1'(ex == 0 && ey == 0), ref_pix(ex, ey)});
      pix_ready = ($urandom_range(99) < ready_pct);
      if (drop_en) enable = 1'b0;
      if (scramble) begin
        ball_pos = $urandom;
        lpad_pos = $urandom;
        rpad_pos = $urandom;
        score    = 16'($urandom);
      end
      if (pix_valid && pix_ready) begin
        beats++;
        if (ex == H - 1 && ey == V - 1) done = 1'b1;
        if (ex == H - 1) begin ex = 0; ey++; end else ex++;
      end
      @(negedge clk);
      cycles++;
    end
    check("beat_count", beats, H * V);
    check("done_pulse", {pix_valid, frame_done}, 2'b01);
    exp_count++;
    check("frame_count", frame_count, 16'(exp_count));
    @(negedge clk);
    check("done_single", {pix_valid, frame_done}, 2'b00);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pix_ready = 1'b0;
    set_inputs(0, 0, 0, 0, 16'h0000);
    repeat (3) @(negedge clk);
    check("rst_outputs", {pix_valid, pix_sof, pix_eol, frame_done, pix_data}, 12'h000);
    check("rst_count", frame_count, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_valid", pix_valid, 1'b0);

    // Reset mid-stream: frame abandoned, not counted.
    set_inputs(10, 3, 5, 5, 16'h0101);
    start_frame();
    pix_ready = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {pix_valid, frame_done, pix_data}, 10'h000);
    check("rst_mid_count", frame_count, 16'h0000);
    rst = 1'b0; enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_idle", {pix_valid, frame_done}, 2'b00);
    end

    // Full-rate frame, inputs scrambled mid-frame to prove the snapshot holds.
    set_inputs(20, 5, 8, 8, 16'h0302);
    start_frame();
    stream_frame(100, 1'b1, 1'b1);

    // Random geometry under 50% back-pressure.
    for (int i = 0; i < 2; i++) begin
      set_inputs($urandom_range(0, H + 8), $urandom_range(0, V + 8),
                 $urandom_range(0, V), $urandom_range(0, V), 16'($urandom));
      start_frame();
      stream_frame(50, 1'b1, 1'b1);
    end

    // Ball clipped at the bottom-right corner.
    set_inputs(H - 4, V - 2, 0, V - 4, 16'h0000);
    start_frame();
    stream_frame(50, 1'b1, 1'b0);

    // Ball near 0xFFFF must not wrap onto the top-left corner.
    set_inputs(16'hFFFC, 16'hFFFE, 16'hFFFA, 16'hFFF0, 16'hFFFF);
    start_frame();
    stream_frame(70, 1'b1, 1'b0);

    // Ball over the left paddle wins.
    set_inputs(LPX + 1, 9, 6, 12, 16'h0000);
    start_frame();
    stream_frame(100, 1'b1, 1'b0);

    // enable held high: DONE, IDLE, LATCH, then the next frame.
    set_inputs($urandom_range(0, H), $urandom_range(0, V), 3, 7, 16'h0000);
    start_frame();
    stream_frame(60, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_latch_gap", pix_valid, 1'b0);
    @(negedge clk);
    check("b2b_first", {pix_valid, pix_sof}, 2'b11);
    stream_frame(60, 1'b1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("idle_after_drop", {pix_valid, frame_done}, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
